// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2^WINDOW_BITS
// samples and presents the saturated count on a valid/ready output.
module bitstream_decoder #(
  parameter int WINDOW_BITS = 8,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   x,
  output logic [WINDOW_BITS-1:0] y,
  output logic                   valid,
  input  logic                   ready,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [WINDOW_BITS-1:0] cycles;
  logic [WINDOW_BITS:0]   ones;
  logic [WINDOW_BITS:0]   ones_next;
  logic [WINDOW_BITS-1:0] y_sat;
  logic                   last;

  // The only count that cannot fit in y is a full all-ones window.
  always_comb begin
    ones_next = ones + {{WINDOW_BITS{1'b0}}, x};
    last      = (cycles == {WINDOW_BITS{1'b1}});
    y_sat     = ones_next[WINDOW_BITS] ? {WINDOW_BITS{1'b1}} : ones_next[WINDOW_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cycles  <= '0;
      ones    <= '0;
      y       <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (valid && ready)
        valid <= 1'b0;

      case (state)
        IDLE: begin
          if (CONTINUOUS || start) begin
            state  <= COUNT;
            busy   <= 1'b1;
            cycles <= '0;
            ones   <= '0;
          end
        end

        COUNT: begin
          cycles <= cycles + 1'b1;
          ones   <= ones_next;
          // A completion overrides any acceptance happening in the same cycle.
          if (last) begin
            y      <= y_sat;
            valid  <= 1'b1;
            ones   <= '0;
            cycles <= '0;
            if (valid && !ready)
              overrun <= 1'b1;
            if (!CONTINUOUS) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
        end

        DONE: begin
          if (valid && ready)
            state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Scoreboard bench for bitstream_decoder: one instance in start-triggered mode,
// one in continuous mode, both with a 16-cycle window.
module tb_bitstream_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic       x0 = 1'b0;
  logic       ready0 = 1'b0;
  logic [3:0] y0;
  logic       valid0, busy0, ovr0;

  logic       rst1 = 1'b1;
  logic       start1 = 1'b0;
  logic       x1 = 1'b0;
  logic       ready1 = 1'b0;
  logic [3:0] y1;
  logic       valid1, busy1, ovr1;

  int total = 0;
  int bad = 0;
  int q0[$];
  int q1[$];

  bitstream_decoder #(.WINDOW_BITS(4), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .x(x0), .y(y0),
    .valid(valid0), .ready(ready0), .busy(busy0), .overrun(ovr0)
  );

  bitstream_decoder #(.WINDOW_BITS(4), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .x(x1), .y(y1),
    .valid(valid1), .ready(ready1), .busy(busy1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic applyStimulus(input int d, input logic s, input logic xv, input logic r);
    @(posedge clk);
    #1;
    if (d == 0) begin
      start0 = s; x0 = xv; ready0 = r;
    end else begin
      start1 = s; x1 = xv; ready1 = r;
    end
  endtask

  // Start a window on dut0 with bits[c-1] in cycle c, then step into cycle 17.
  task automatic runWindow0(input logic [15:0] bits, input logic r, input int expY,
                            input int startAgainAt);
    q0.push_back(expY);
    applyStimulus(0, 1'b1, 1'b0, r);
    @(negedge clk);
    checkOutput("busy_before_count", int'(busy0), 0);
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(0, (c == startAgainAt), bits[c-1], r);
      @(negedge clk);
      if (c == 1)  checkOutput("busy_in_count", int'(busy0), 1);
      if (c == 16) checkOutput("valid_early", int'(valid0), 0);
    end
    applyStimulus(0, 1'b0, 1'b0, r);
    @(negedge clk);
    checkOutput("valid_cycle17", int'(valid0), 1);
    checkOutput("y_cycle17", int'(y0), expY);
    checkOutput("busy_after_window", int'(busy0), 0);
  endtask

  // Scoreboard monitors: compare whenever a handshake is about to occur.
  always @(negedge clk) begin
    if (!rst && valid0 && ready0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL sb0_unexpected: actual=%0d required=none", y0);
      end else
        checkOutput("sb0_y", int'(y0), q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst1 && valid1 && ready1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL sb1_unexpected: actual=%0d required=none", y1);
      end else
        checkOutput("sb1_y", int'(y1), q1.pop_front());
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_y", int'(y0), 0);
    checkOutput("rst_valid", int'(valid0), 0);
    checkOutput("rst_busy", int'(busy0), 0);
    checkOutput("rst_overrun", int'(ovr0), 0);
    checkOutput("rst1_busy", int'(busy1), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Alternating bits, a stray start mid-window, then a held result.
    runWindow0(16'h5555, 1'b0, 8, 5);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("hold_valid", int'(valid0), 1);
      checkOutput("hold_y", int'(y0), 8);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("accept_valid", int'(valid0), 0);
    checkOutput("accept_busy", int'(busy0), 0);

    runWindow0(16'h0000, 1'b1, 0, 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("zeros_drained", int'(valid0), 0);

    runWindow0(16'hFFFF, 1'b1, 15, 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ones_drained", int'(valid0), 0);
    checkOutput("overrun0_clear", int'(ovr0), 0);

    // Asynchronous reset in cycle 7 of a window.
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 7; c++) applyStimulus(0, 1'b0, 1'b1, 1'b1);
    #2;
    checkOutput("pre_rst_busy", int'(busy0), 1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", int'(busy0), 0);
    checkOutput("async_rst_valid", int'(valid0), 0);
    checkOutput("async_rst_y", int'(y0), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    runWindow0(16'h001F, 1'b1, 5, 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_drained", int'(valid0), 0);

    // Continuous mode, ready held low: second result overwrites and flags overrun.
    @(posedge clk);
    #1 rst1 = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      applyStimulus(1, 1'b0, (c <= 3) || (c >= 17 && c <= 26), 1'b0);
      @(negedge clk);
      if (c == 1) checkOutput("cont_busy", int'(busy1), 1);
      if (c == 17) begin
        checkOutput("cont_w1_valid", int'(valid1), 1);
        checkOutput("cont_w1_y", int'(y1), 3);
        checkOutput("cont_w1_overrun", int'(ovr1), 0);
      end
    end
    checkOutput("cont_w2_valid", int'(valid1), 1);
    checkOutput("cont_w2_y", int'(y1), 10);
    checkOutput("cont_w2_overrun", int'(ovr1), 1);

    @(posedge clk);
    #1 rst1 = 1'b1;
    #2;
    checkOutput("rst1_overrun", int'(ovr1), 0);
    checkOutput("rst1_valid", int'(valid1), 0);
    checkOutput("rst1_y", int'(y1), 0);

    // Continuous mode, ready only in the completion cycle: no overrun.
    q1.push_back(6);
    q1.push_back(15);
    @(posedge clk);
    #1 rst1 = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      applyStimulus(1, 1'b0, (c <= 6) || (c >= 17 && c <= 32), (c == 32) || (c == 34));
      @(negedge clk);
      if (c == 17) checkOutput("cont_w3_y", int'(y1), 6);
      if (c == 33) begin
        checkOutput("cont_w4_valid", int'(valid1), 1);
        checkOutput("cont_w4_y", int'(y1), 15);
        checkOutput("cont_w4_overrun", int'(ovr1), 0);
      end
      if (c == 35) checkOutput("cont_drained", int'(valid1), 0);
    end
    @(posedge clk);
    #1 rst1 = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("sb0_leftover", q0.size(), 0);
    checkOutput("sb1_leftover", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitstream_decoder.md
BITSTREAM_DECODER -- requirements
Module: bitstream_decoder

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-002 The module SHALL have parameter WINDOW_BITS, default 8, meaning the log2 of the observation window length in cycles (window = 2^WINDOW_BITS).
REQ-003 The module SHALL have parameter CONTINUOUS, default 0, meaning 1 = start the next window automatically, 0 = wait for start.
REQ-004 The module SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 The module SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 The module SHALL have port start  input  1  one-cycle request to begin a window; used only when CONTINUOUS=0.
REQ-007 The module SHALL have port x  input  1  stochastic bitstream to decode.
REQ-008 The module SHALL have port y  output  WINDOW_BITS  decoded value, the count of ones in the last window.
REQ-009 The module SHALL have port valid  output  1  y holds an unaccepted result.
REQ-010 The module SHALL have port ready  input  1  consumer accepts y when valid&ready.
REQ-011 The module SHALL have port busy  output  1  a window is in progress.
REQ-012 The module SHALL have port overrun  output  1  sticky flag: a result was lost.

Function
REQ-013 The module SHALL have states IDLE, COUNT and DONE.
REQ-014 In IDLE with CONTINUOUS=0, start=1 SHALL move the module to COUNT, clear the ones counter and clear the cycle counter; x in the start cycle SHALL NOT be counted.
REQ-015 With CONTINUOUS=1, the module SHALL leave IDLE for COUNT on the first clock after reset deassertion and SHALL ignore start.
REQ-016 In COUNT, each cycle SHALL increment the cycle counter, and SHALL increment the ones counter when x=1.
REQ-017 The ones counter SHALL be WINDOW_BITS+1 bits wide so that an all-ones window of 2^WINDOW_BITS cannot wrap.
REQ-018 After exactly 2^WINDOW_BITS sampled cycles, on the cycle that samples the last bit, the module SHALL load y with min(count, 2^WINDOW_BITS-1) and set valid=1 on the following edge; an all-ones window therefore yields all ones on y (saturation).
REQ-019 Latency SHALL be: with start at cycle 0, bits are sampled in cycles 1..2^WINDOW_BITS, and valid is first high in cycle 2^WINDOW_BITS+1.
REQ-020 After loading y, with CONTINUOUS=0 the module SHALL go to DONE; with CONTINUOUS=1 it SHALL remain in COUNT with both counters cleared, with no gap cycle.
REQ-021 y and valid SHALL hold stable while valid=1 and ready=0.
REQ-022 valid&ready SHALL clear valid on the next edge; ready while valid=0 SHALL have no effect.
REQ-023 In DONE, on acceptance, the module SHALL return to IDLE; start is ignored while in DONE or COUNT.
REQ-024 If a new result completes while valid=1 and ready=0 in the same cycle, y SHALL be overwritten with the new value, valid SHALL stay 1 and overrun SHALL be set.
REQ-025 If ready=1 in that completion cycle, the old value SHALL be accepted, the new value loaded, valid SHALL stay 1 and no overrun SHALL be raised.
REQ-026 overrun SHALL clear only on reset.
REQ-027 busy SHALL be 1 exactly in state COUNT.

Reset
REQ-028 Assertion of rst SHALL immediately, independent of clk, force state IDLE, counters 0, y=0, valid=0, busy=0 and overrun=0.
REQ-029 Reset during COUNT SHALL discard the partial window; no result SHALL be produced.
REQ-030 The first window after reset release SHALL be a full 2^WINDOW_BITS cycles.

Verification
REQ-031 WINDOW_BITS=4, CONTINUOUS=0, start, x=1 every other cycle -> valid in cycle 17 with y=8.
REQ-032 WINDOW_BITS=4, x constant 1 -> y=15 (saturated); x constant 0 -> y=0.
REQ-033 ready=0 held for 10 cycles after valid -> y and valid stable; ready=1 -> valid=0 next cycle, state IDLE, busy=0.
REQ-034 CONTINUOUS=1, ready tied 0, two windows -> second y overwrites, valid=1, overrun=1; repeat with ready=1 in the completion cycle -> overrun stays 0.
REQ-035 rst pulse mid-COUNT at cycle 7 -> outputs zero asynchronously; a subsequent start yields a correct full-window count.
REQ-036 start asserted while busy -> ignored; the window count and timing are unchanged.
